// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a three-digit, seven-segment display.
// Each digit is lit for REFRESH_DIV cycles, followed by BLANK_CYCLES dark
// cycles. New digit patterns are staged in a shadow register and only become
// visible at a frame boundary, so a frame never shows a mix of old and new digits.
// All outputs are registered and computed from next-state values, so they
// line up with the FSM state of the same cycle.
module seg_scan_driver #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    output logic [6:0] seg_out,
    output logic [2:0] an,
    output logic       frame_done
);

    // One counter serves both the slot and the blank phase; it is sized for the longer one.
    localparam int MAXC_RAW  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int MAXC      = (MAXC_RAW < 2) ? 2 : MAXC_RAW;
    localparam int CW        = $clog2(MAXC);
    localparam int BC_LAST_I = (BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0;

    localparam logic [CW-1:0] RD_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BC_LAST = CW'(BC_LAST_I);

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        BLANK = 1'b1
    } state_t;

    state_t        state_r,   state_s;
    logic [1:0]    digit_r,   digit_s;
    logic [CW-1:0] cnt_r,     cnt_s;
    logic          run_r,     run_s;
    logic [20:0]   shadow_r,  shadow_s;
    logic [20:0]   display_r, display_s;
    logic          pending_r, pending_s;
    logic          boundary_s;
    logic [2:0]    an_s;
    logic [6:0]    seg_s;
    logic          frame_done_s;

    function automatic logic [2:0] onehot3(input logic [1:0] d);
        logic [2:0] r;
        case (d)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] next_digit(input logic [1:0] d);
        logic [1:0] r;
        case (d)
            2'd0:    r = 2'd1;
            2'd1:    r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] pick_digit(input logic [20:0] disp, input logic [1:0] d);
        logic [6:0] r;
        case (d)
            2'd0:    r = disp[6:0];
            2'd1:    r = disp[13:7];
            2'd2:    r = disp[20:14];
            default: r = 7'b0000000;
        endcase
        return r;
    endfunction

    // Next-state, load/display staging and next output values.
    always_comb begin
        state_s      = state_r;
        digit_s      = digit_r;
        cnt_s        = cnt_r;
        run_s        = run_r;
        boundary_s   = 1'b0;
        shadow_s     = shadow_r;
        display_s    = display_r;
        pending_s    = pending_r;
        an_s         = 3'b000;
        seg_s        = 7'b0000000;
        frame_done_s = 1'b0;

        if (!en) begin
            // Held parked so that enabling starts cleanly at cycle 0 of digit 0.
            state_s = SHOW;
            digit_s = 2'd0;
            cnt_s   = '0;
            run_s   = 1'b0;
        end else if (!run_r) begin
            // First enabled cycle: enter SHOW(0) without a frame pulse.
            state_s = SHOW;
            digit_s = 2'd0;
            cnt_s   = '0;
            run_s   = 1'b1;
        end else begin
            case (state_r)
                SHOW: begin
                    if (cnt_r == RD_LAST) begin
                        cnt_s = '0;
                        if (BLANK_CYCLES > 0) begin
                            state_s = BLANK;
                        end else begin
                            state_s    = SHOW;
                            digit_s    = next_digit(digit_r);
                            boundary_s = (digit_r == 2'd2);
                        end
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                BLANK: begin
                    if (cnt_r == BC_LAST) begin
                        cnt_s      = '0;
                        state_s    = SHOW;
                        digit_s    = next_digit(digit_r);
                        boundary_s = (digit_r == 2'd2);
                    end else begin
                        cnt_s = cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_s = SHOW;
                    digit_s = 2'd0;
                    cnt_s   = '0;
                end
            endcase
        end

        // A staged pattern is promoted at a frame boundary, or immediately while disabled.
        if ((!en || boundary_s) && pending_r) begin
            display_s = shadow_r;
            pending_s = 1'b0;
        end else begin
            display_s = display_r;
            pending_s = pending_r;
        end

        // A new load always wins the shadow and re-arms pending, even on a boundary edge.
        if (load) begin
            shadow_s  = {seg3, seg2, seg1};
            pending_s = 1'b1;
        end else begin
            shadow_s = shadow_r;
        end

        if (en && (state_s == SHOW)) begin
            an_s  = onehot3(digit_s);
            seg_s = pick_digit(display_s, digit_s);
        end else begin
            an_s  = 3'b000;
            seg_s = 7'b0000000;
        end
        frame_done_s = boundary_s;
    end

    // State, staging and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= SHOW;
            digit_r    <= 2'd0;
            cnt_r      <= '0;
            run_r      <= 1'b0;
            shadow_r   <= 21'd0;
            display_r  <= 21'd0;
            pending_r  <= 1'b0;
            an         <= 3'b000;
            seg_out    <= 7'b0000000;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            digit_r    <= digit_s;
            cnt_r      <= cnt_s;
            run_r      <= run_s;
            shadow_r   <= shadow_s;
            display_r  <= display_s;
            pending_r  <= pending_s;
            an         <= an_s;
            seg_out    <= seg_s;
            frame_done <= frame_done_s;
        end
    end

endmodule
